// File: rtl/spi_readback_tx.sv
// Readback transmitter for the host SPI config link: streams a snapshot of key, nonce,
// position or the ID byte to the SPI slave TX port, one byte per slave byte slot, plus an optional XOR checksum.
module spi_readback_tx #(
    parameter bit         CHECKSUM_EN = 1'b1,
    parameter logic [7:0] ID_BYTE     = 8'hC5
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_rd_req,
    input  logic [1:0]   i_rd_sel,
    input  logic         i_abort,
    input  logic [255:0] i_key,
    input  logic [95:0]  i_nonce,
    input  logic [31:0]  i_position,
    input  logic         i_RX_DV,
    output logic         o_TX_DV,
    output logic [7:0]   o_TX_Byte,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [1:0]   o_dbg_state
);

    // Handshake: every i_RX_DV marks one consumed byte slot; the next byte (if any) is
    // offered with a one-cycle o_TX_DV pulse in the cycle after, never more than one per slot.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DATA = 2'd2,
        WAIT_CK   = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [255:0] r_shadow;
    logic [255:0] w_shadow_nxt;
    logic [4:0]   r_idx;
    logic [4:0]   w_idx_nxt;
    logic [4:0]   r_last;
    logic [4:0]   w_last_nxt;
    logic [7:0]   r_ck;
    logic [7:0]   w_ck_nxt;
    logic         r_tx_dv;
    logic         w_tx_dv_nxt;
    logic [7:0]   r_tx_byte;
    logic [7:0]   w_tx_byte_nxt;
    logic         r_busy;
    logic         w_busy_nxt;
    logic         r_done;
    logic         w_done_nxt;
    logic         r_err;
    logic         w_err_nxt;

    logic [255:0] w_snapshot;
    logic [4:0]   w_snap_last;
    logic [4:0]   w_idx_inc;
    logic [7:0]   w_byte_cur;
    logic [7:0]   w_byte_next;

    // Selected field, zero-extended into the shadow layout; r_last holds length-1.
    always_comb begin
        w_snapshot  = '0;
        w_snap_last = 5'd0;
        case (i_rd_sel)
            2'd0: begin
                w_snapshot  = i_key;
                w_snap_last = 5'd31;
            end
            2'd1: begin
                w_snapshot  = {160'd0, i_nonce};
                w_snap_last = 5'd11;
            end
            2'd2: begin
                w_snapshot  = {224'd0, i_position};
                w_snap_last = 5'd3;
            end
            default: begin
                w_snapshot  = {248'd0, ID_BYTE};
                w_snap_last = 5'd0;
            end
        endcase
    end

    assign w_idx_inc   = r_idx + 5'd1;
    assign w_byte_cur  = r_shadow[{r_idx, 3'b000} +: 8];
    assign w_byte_next = r_shadow[{w_idx_inc, 3'b000} +: 8];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_idx     <= 5'd0;
            r_last    <= 5'd0;
            r_ck      <= 8'd0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shadow  <= w_shadow_nxt;
            r_idx     <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_ck      <= w_ck_nxt;
            r_tx_dv   <= w_tx_dv_nxt;
            r_tx_byte <= w_tx_byte_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        w_ck_nxt      = r_ck;
        w_tx_dv_nxt   = 1'b0;
        w_tx_byte_nxt = r_tx_byte;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_rd_req) begin
                    w_shadow_nxt = w_snapshot;
                    w_last_nxt   = w_snap_last;
                    w_idx_nxt    = 5'd0;
                    w_ck_nxt     = 8'd0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = SEND;
                end
            end
            SEND: begin
                w_tx_dv_nxt   = 1'b1;
                w_tx_byte_nxt = w_byte_cur;
                w_ck_nxt      = r_ck ^ w_byte_cur;
                w_state_nxt   = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (i_RX_DV) begin
                    if (r_idx != r_last) begin
                        w_idx_nxt     = w_idx_inc;
                        w_tx_dv_nxt   = 1'b1;
                        w_tx_byte_nxt = w_byte_next;
                        w_ck_nxt      = r_ck ^ w_byte_next;
                    end else if (CHECKSUM_EN) begin
                        w_tx_dv_nxt   = 1'b1;
                        w_tx_byte_nxt = r_ck;
                        w_state_nxt   = WAIT_CK;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_CK: begin
                if (i_RX_DV) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A request during a stream is refused but never disturbs it; abort wins over i_RX_DV.
        if (r_state != IDLE) begin
            w_err_nxt = i_rd_req;
            if (i_abort) begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_tx_dv_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        end
    end

    assign o_TX_DV     = r_tx_dv;
    assign o_TX_Byte   = r_tx_byte;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_readback_tx.sv
// Bench for spi_readback_tx: a byte-queue model of the readback stream checked every cycle,
// plus literal expectations per scenario and a small no-checksum build.
module tb_spi_readback_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req = 1'b0;
    logic [1:0]   rd_sel = 2'd0;
    logic         abort = 1'b0;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [31:0]  position = '0;
    logic         rx_dv = 1'b0;
    logic         tx_dv;
    logic [7:0]   tx_byte;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   dbg_state;

    logic         n_req = 1'b0;
    logic         n_rx = 1'b0;
    logic         n_tx_dv;
    logic [7:0]   n_tx_byte;
    logic         n_busy;
    logic         n_done;
    logic         n_err;
    logic [1:0]   n_dbg_state;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_readback_tx #(.CHECKSUM_EN(1'b1), .ID_BYTE(8'hC5)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_rd_req(rd_req), .i_rd_sel(rd_sel), .i_abort(abort),
        .i_key(key), .i_nonce(nonce), .i_position(position), .i_RX_DV(rx_dv),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_busy(busy), .o_done(done), .o_err(err),
        .o_dbg_state(dbg_state)
    );

    spi_readback_tx #(.CHECKSUM_EN(1'b0), .ID_BYTE(8'hC5)) u_nock (
        .i_Clk(clk), .i_Rst(rst), .i_rd_req(n_req), .i_rd_sel(2'd2), .i_abort(1'b0),
        .i_key(key), .i_nonce(nonce), .i_position(position), .i_RX_DV(n_rx),
        .o_TX_DV(n_tx_dv), .o_TX_Byte(n_tx_byte), .o_busy(n_busy), .o_done(n_done), .o_err(n_err),
        .o_dbg_state(n_dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request queues every byte the host will see; each slot pops the next one.
    logic [7:0] exp_q[$];
    int         m_phase = 0;
    logic       e_tx_dv = 1'b0;
    logic [7:0] e_byte = 8'd0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    logic       e_err = 1'b0;

    function automatic int field_len(input logic [1:0] sel);
        case (sel)
            2'd0: return 32;
            2'd1: return 12;
            2'd2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] field_byte(input logic [1:0] sel, input int n);
        case (sel)
            2'd0: return key[n*8 +: 8];
            2'd1: return nonce[n*8 +: 8];
            2'd2: return position[n*8 +: 8];
            default: return 8'hC5;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_phase = 0;
            e_tx_dv = 1'b0;
            e_byte  = 8'd0;
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_err   = 1'b0;
        end else begin
            e_tx_dv = 1'b0;
            e_done  = 1'b0;
            e_err   = 1'b0;
            if (m_phase == 0) begin
                if (rd_req) begin
                    logic [7:0] ck;
                    ck = 8'd0;
                    exp_q.delete();
                    for (int n = 0; n < field_len(rd_sel); n++) begin
                        exp_q.push_back(field_byte(rd_sel, n));
                        ck = ck ^ field_byte(rd_sel, n);
                    end
                    exp_q.push_back(ck);
                    m_phase = 1;
                    e_busy  = 1'b1;
                end
            end else begin
                if (rd_req) e_err = 1'b1;
                if (abort) begin
                    exp_q.delete();
                    m_phase = 0;
                    e_busy  = 1'b0;
                end else if (m_phase == 1) begin
                    e_byte  = exp_q.pop_front();
                    e_tx_dv = 1'b1;
                    m_phase = 2;
                end else if (rx_dv) begin
                    if (exp_q.size() > 0) begin
                        e_byte  = exp_q.pop_front();
                        e_tx_dv = 1'b1;
                    end else begin
                        e_done  = 1'b1;
                        e_busy  = 1'b0;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    logic [7:0] tx_log[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int n_tx_cnt = 0;
    int n_done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_dv", {31'd0, tx_dv}, {31'd0, e_tx_dv});
            check("tx_byte", {24'd0, tx_byte}, {24'd0, e_byte});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("err", {31'd0, err}, {31'd0, e_err});
            if (tx_dv) tx_log.push_back(tx_byte);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (n_tx_dv) n_tx_cnt++;
            if (n_done) n_done_cnt++;
        end
    end

    task automatic request(input logic [1:0] sel);
        @(negedge clk);
        rd_req = 1'b1;
        rd_sel = sel;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rx_pulse(input int gap);
        @(negedge clk);
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        chk_en = 1'b1;

        // 1: position readback with checksum
        position = 32'h44332211;
        tx_log.delete();
        request(2'd2);
        for (int i = 0; i < 5; i++) rx_pulse(7);
        repeat (2) @(negedge clk);
        check("t1_count", tx_log.size(), 32'd5);
        if (tx_log.size() == 5) begin
            check("t1_b0", {24'd0, tx_log[0]}, 32'h11);
            check("t1_b3", {24'd0, tx_log[3]}, 32'h44);
            check("t1_ck", {24'd0, tx_log[4]}, 32'h44);
        end
        check("t1_done", done_cnt, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: full key, byte n = n
        for (int n = 0; n < 32; n++) key[n*8 +: 8] = n[7:0];
        tx_log.delete();
        request(2'd0);
        for (int i = 0; i < 33; i++) rx_pulse(1);
        wait_idle();
        check("t2_count", tx_log.size(), 32'd33);
        if (tx_log.size() == 33) begin
            check("t2_b0", {24'd0, tx_log[0]}, 32'h00);
            check("t2_b31", {24'd0, tx_log[31]}, 32'h1F);
            check("t2_ck", {24'd0, tx_log[32]}, 32'h00);
        end
        check("t2_done", done_cnt, 32'd2);

        // 3: nonce changes after the first byte; stream keeps the original
        nonce = 96'h0102_0304_0506_0708_090A_0B0C;
        tx_log.delete();
        request(2'd1);
        rx_pulse(1);
        nonce = '1;
        for (int i = 0; i < 12; i++) rx_pulse(2);
        wait_idle();
        check("t3_count", tx_log.size(), 32'd13);
        if (tx_log.size() == 13) begin
            check("t3_b0", {24'd0, tx_log[0]}, 32'h0C);
            check("t3_b11", {24'd0, tx_log[11]}, 32'h01);
            check("t3_ck", {24'd0, tx_log[12]}, 32'h0C);
        end

        // 4: requests during a key stream, including on the final slot
        tx_log.delete();
        err_cnt = 0;
        request(2'd0);
        for (int i = 0; i < 3; i++) rx_pulse(1);
        request(2'd2);
        for (int i = 3; i < 32; i++) rx_pulse(1);
        @(negedge clk);
        rx_dv  = 1'b1;
        rd_req = 1'b1;
        rd_sel = 2'd2;
        @(negedge clk);
        rx_dv  = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_err", err_cnt, 32'd2);
        check("t4_count", tx_log.size(), 32'd33);
        if (tx_log.size() == 33) check("t4_b31", {24'd0, tx_log[31]}, 32'h1F);
        check("t4_idle", {31'd0, busy}, 32'd0);
        rx_pulse(1);
        check("t4_no_tx", tx_log.size(), 32'd33);

        // 5: abort after two nonce bytes, then an ID read
        tx_log.delete();
        base = done_cnt;
        request(2'd1);
        rx_pulse(1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        rx_pulse(2);
        check("t5_bytes", tx_log.size(), 32'd2);
        check("t5_no_done", done_cnt, base);
        request(2'd3);
        rx_pulse(1);
        rx_pulse(1);
        check("t5_id_count", tx_log.size(), 32'd4);
        if (tx_log.size() == 4) begin
            check("t5_id", {24'd0, tx_log[2]}, 32'hC5);
            check("t5_id_ck", {24'd0, tx_log[3]}, 32'hC5);
        end
        check("t5_done", done_cnt, base + 1);

        // abort and request together in IDLE: request wins
        tx_log.delete();
        @(negedge clk);
        rd_req = 1'b1;
        rd_sel = 2'd3;
        abort  = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        abort  = 1'b0;
        rx_pulse(1);
        rx_pulse(1);
        check("t5b_count", tx_log.size(), 32'd2);

        // 6: asynchronous reset mid key stream
        tx_log.delete();
        request(2'd0);
        for (int i = 0; i < 4; i++) rx_pulse(1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_tx_dv", {31'd0, tx_dv}, 32'd0);
        check("t6_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_log.delete();
        for (int i = 0; i < 3; i++) rx_pulse(1);
        check("t6_silent", tx_log.size(), 32'd0);

        // 7: no-checksum build on position
        n_tx_cnt   = 0;
        n_done_cnt = 0;
        @(negedge clk);
        n_req = 1'b1;
        @(negedge clk);
        n_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_rx = 1'b1;
            @(negedge clk);
            n_rx = 1'b0;
            if (i == 3) check("t7_done_lat", {31'd0, n_done}, 32'd1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("t7_tx_count", n_tx_cnt, 32'd4);
        check("t7_done", n_done_cnt, 32'd1);
        check("t7_busy", {31'd0, n_busy}, 32'd0);
        check("t7_byte", {24'd0, n_tx_byte}, 32'h44);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
